fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Front end of the 16-bit core: generates instruction-fetch addresses, buffers returned 16-bit instructions with their PCs, and presents them to decode/execute.
- Consumes the execute stage's next-PC output (PC2) as a redirect: flushes the buffer, discards stale in-flight fetches and restarts at the new PC.
- Sits between instruction memory and decode, on the opposite side of the PC2 loop from execute.

Parameters:
- DEPTH, 4, instruction buffer entries; also the cap on (outstanding requests + buffered entries). Power of two, >= 2.
- RESET_PC, 16'h0000, fetch PC loaded on reset.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  output  1  fetch request valid
- req_ready  input  1  memory accepts request
- req_addr  output  16  fetch byte address, always even
- resp_valid  input  1  in-order fetch response valid
- resp_data  input  16  fetched instruction
- inst_valid  output  1  buffered instruction available
- inst_ready  input  1  decode accepts instruction
- inst  output  16  instruction at buffer head
- inst_pc  output  16  PC of inst
- redirect_valid  input  1  execute redirect (taken branch / jmp)
- redirect_pc  input  16  new PC (execute's PC2); bit 0 ignored, forced to 0

Behaviour:
- Clock is clk; reset is synchronous and active-high. During reset and on the first edge after it, all state clears:
  - fetch_pc = resp_pc = RESET_PC;
  - outstanding = drop_count = buffer count = 0;
  - req_valid = 0 and inst_valid = 0 while reset is high.
- Request issue:
  - req_valid = !reset && !redirect_valid && (outstanding + count) < DEPTH.
  - req_addr = fetch_pc.
  - On req_valid && req_ready: fetch_pc += 2 (mod 2^16, so 16'hFFFE wraps to 0) and outstanding += 1.
- Response retire:
  - resp_valid is honoured only when outstanding > 0; otherwise it is ignored as a protocol error. Each honoured response decrements outstanding.
  - If drop_count > 0, the response is discarded and drop_count -= 1.
  - Otherwise {resp_data, resp_pc} is pushed to the buffer and resp_pc += 2 (mod 2^16).
  - The credit rule guarantees a push never overflows the buffer.
- Output:
  - inst_valid = count != 0 && !redirect_valid; inst and inst_pc come from the buffer head.
  - Pop on inst_valid && inst_ready.
  - Push and pop in the same cycle is legal at any occupancy; count is unchanged.
  - A pushed entry becomes visible on the next cycle (one-cycle response-to-inst latency).
- Redirect (redirect_valid=1), taking effect at the next edge:
  - the buffer is flushed (count = 0; any push or pop this cycle is discarded);
  - fetch_pc and resp_pc are loaded with {redirect_pc[15:1],1'b0};
  - drop_count = outstanding after this cycle's retire, i.e. minus 1 if a response was honoured this cycle. A response arriving in the redirect cycle is discarded regardless of drop_count.
  - No request fires in a redirect cycle, because req_valid is forced low.
  - Redirects on consecutive cycles are legal; the last one wins. drop_count is recomputed each time and never drops below 0.
- Reset mid-operation: all in-flight requests are forgotten. Memory must be reset together with this block.
- No combinational path from resp_* to inst_*. Combinational paths exist from redirect_valid to req_valid and inst_valid.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined: adds output ports stat_redirects[15:0] and stat_dropped[15:0].
  - Saturating counters, cleared by reset.
  - stat_redirects increments on each redirect cycle.
  - stat_dropped increments for each discarded response: drop_count-driven discards plus the response discarded in a redirect cycle.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset; memory always ready, 1-cycle response, data = addr ^ 16'hA5A5; inst_ready=1 -> inst_pc runs 0x0000, 0x0002, 0x0004, ..., each inst = pc ^ 16'hA5A5, and after warm-up one instruction is delivered per cycle.
- inst_ready=0 from reset -> exactly 4 requests issued (0x0000–0x0006), then req_valid stays 0. Raise inst_ready -> next req_addr = 0x0008; no entries lost or duplicated.
- Memory latency 3 cycles, redirect_pc=16'h0101 with 2 requests outstanding -> both stale responses dropped; next inst_pc = 16'h0100, inst = 16'h0100 ^ 16'hA5A5; stale data never reaches inst.
- RESET_PC=16'hFFFC -> req_addr sequence FFFC, FFFE, 0000, 0002; inst_pc wraps identically.
- redirect_valid asserted in the same cycle as resp_valid, req_ready=1 and inst_ready=1 with the buffer full -> req_valid=0 and inst_valid=0 that cycle. Next cycle: count=0 and req_addr = redirect target; the concurrent response is not delivered.
- With FETCH_STATS_EN: the two redirects above -> stat_redirects=2 and stat_dropped equals the number of discarded responses. Force 70000 redirects -> stat_redirects saturates at 16'hFFFF.

Source files
------------

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit handshake bundle: memory request/response, decode output, execute redirect
interface fetch_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        redirect_valid;
  logic [15:0] redirect_pc;

  modport master (
    output req_valid, req_addr, inst_valid, inst, inst_pc,
    input  req_ready, resp_valid, resp_data, inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  req_valid, req_addr, inst_valid, inst, inst_pc,
    output req_ready, resp_valid, resp_data, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - credit-limited instruction fetch with redirect flush; FETCH_STATS_EN adds redirect/drop counters
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]   stat_redirects,
  output logic [15:0]   stat_dropped
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic [15:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   buf_q [DEPTH];

  logic          redirect;
  logic [15:0]   target_pc;
  logic [CW:0]   in_use;
  logic          req_valid;
  logic          req_fire;
  logic          resp_ok;
  logic          push;
  logic          inst_valid;
  logic          pop;

  assign redirect  = bus.redirect_valid;
  assign target_pc = {bus.redirect_pc[15:1], 1'b0};
  // Outstanding requests hold a buffer slot in reserve, so a push can never overflow.
  assign in_use    = {1'b0, outstanding_q} + {1'b0, count_q};

  assign req_valid  = !reset && !redirect && (in_use < (CW+1)'(DEPTH));
  assign req_fire   = req_valid && bus.req_ready;
  assign resp_ok    = bus.resp_valid && (outstanding_q != '0);
  assign push       = resp_ok && !redirect && (drop_q == '0);
  assign inst_valid = !reset && !redirect && (count_q != '0);
  assign pop        = inst_valid && bus.inst_ready;

  assign bus.req_valid  = req_valid;
  assign bus.req_addr   = fetch_pc_q;
  assign bus.inst_valid = inst_valid;
  assign bus.inst       = buf_q[rd_ptr_q][31:16];
  assign bus.inst_pc    = buf_q[rd_ptr_q][15:0];

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_d        = drop_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_ok);

    if (redirect) begin
      // Everything still in flight after this cycle's retire is stale.
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      drop_d     = outstanding_q - CW'(resp_ok);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 16'd2;
      end
      if (resp_ok && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        wr_ptr_d  = wr_ptr_q + AW'(1);
        resp_pc_d = resp_pc_q + 16'd2;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wr_ptr_q] <= {bus.resp_data, resp_pc_q};
    end
  end

`ifdef FETCH_STATS_EN
  logic [15:0] stat_redirects_q;
  logic [15:0] stat_dropped_q;
  logic        drop_event;

  assign drop_event     = resp_ok && (redirect || (drop_q != '0));
  assign stat_redirects = stat_redirects_q;
  assign stat_dropped   = stat_dropped_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_redirects_q <= '0;
      stat_dropped_q   <= '0;
    end else begin
      if (redirect && (stat_redirects_q != 16'hFFFF)) begin
        stat_redirects_q <= stat_redirects_q + 16'd1;
      end
      if (drop_event && (stat_dropped_q != 16'hFFFF)) begin
        stat_dropped_q <= stat_dropped_q + 16'd1;
      end
    end
  end
`endif

endmodule
